// File: rtl/posit_add.sv
// posit_add: single-cycle registered posit adder (standard posits, N bits,
// es exponent bits). Operands captured on a start edge; result, NaR/zero
// flags and a one-cycle done pulse appear after that same edge.
module posit_add #(
  parameter int N  = 16,
  parameter int es = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in2,
  input  logic         start,
  output logic [N-1:0] out,
  output logic         inf,
  output logic         zero,
  output logic         done
);

  localparam int FW   = N - 1 - es;         // max fraction bits after decode
  localparam int SW   = FW + 1;             // significand incl. hidden bit
  localparam int AW   = SW + 3;             // aligned width: sig, guard, round, sticky
  localparam int WW   = 2 * SW + 2;         // alignment shifter window
  localparam int XW   = 4 * N;              // encode window (regime + exp + frac)
  localparam int XPAD = XW - 2 - es - AW;
  localparam int SCW  = 10;                 // signed scale width
  localparam int CW   = $clog2(N) + 1;      // regime run counter
  localparam int LW   = $clog2(AW + 1);     // leading-one position

  localparam logic [N-1:0]          NAR  = {1'b1, {(N-1){1'b0}}};
  localparam logic signed [SCW-1:0] KMAX = SCW'(N - 2);

  typedef struct packed {
    logic signed [SCW-1:0] sc;
    logic [SW-1:0]         sig;
  } dec_t;

  // Decode a nonzero, non-NaR posit into scale and significand (hidden 1).
  function automatic dec_t decode(input logic [N-1:0] x);
    logic [N-2:0]          body;
    logic [N-2:0]          rem;
    logic                  rb;
    logic                  run;
    logic [CW-1:0]         m;
    logic signed [SCW-1:0] k;
    logic [es-1:0]         e;
    dec_t                  d;
    body = x[N-1] ? -x[N-2:0] : x[N-2:0];
    rb   = body[N-2];
    run  = 1'b1;
    m    = '0;
    for (int unsigned i = 0; i < N - 1; i++) begin
      if (run && (body[N-2-i] == rb)) m = m + CW'(1);
      else run = 1'b0;
    end
    rem   = body << (m + CW'(1));
    e     = rem[N-2 -: es];
    k     = rb ? (SCW'(m) - SCW'(1)) : -SCW'(m);
    d.sc  = (k <<< es) + SCW'(e);
    d.sig = {1'b1, rem[FW-1:0]};
    return d;
  endfunction

  dec_t                  w_d1, w_d2, w_big, w_small;
  logic [N-2:0]          w_abs1, w_abs2;
  logic                  w_swap, w_sign, w_sub;
  logic [SCW-1:0]        w_diff;
  logic [WW-1:0]         w_wide, w_shf;
  logic [AW-1:0]         w_al_b, w_al_s;
  logic [AW:0]           w_sum, w_norm;
  logic [LW-1:0]         w_lead;
  logic signed [SCW-1:0] w_nsc, w_k;
  logic [SCW-1:0]        w_sh;
  logic signed [XW-1:0]  w_x, w_xs;
  logic [N-2:0]          w_body;
  logic                  w_rnd, w_st;
  logic [N-1:0]          w_mag_out, w_out;

  logic [N-1:0]          r_out;
  logic                  r_inf, r_zero, r_done;

  // Full decode / align / add / normalise / encode path.
  always_comb begin
    w_d1   = decode(in1);
    w_d2   = decode(in2);
    // Posit magnitude order equals integer order of the absolute encodings.
    w_abs1 = in1[N-1] ? -in1[N-2:0] : in1[N-2:0];
    w_abs2 = in2[N-1] ? -in2[N-2:0] : in2[N-2:0];
    w_swap  = w_abs2 > w_abs1;
    w_big   = w_swap ? w_d2 : w_d1;
    w_small = w_swap ? w_d1 : w_d2;
    w_sign  = w_swap ? in2[N-1] : in1[N-1];
    w_sub   = in1[N-1] ^ in2[N-1];

    w_diff = w_big.sc - w_small.sc;
    w_wide = {w_small.sig, {(SW+2){1'b0}}};
    w_shf  = (w_diff >= SCW'(WW)) ? '0 : (w_wide >> w_diff);
    w_al_b = {w_big.sig, 3'b000};
    w_al_s = {w_shf[WW-1 -: SW+2], |w_shf[SW-1:0]};
    w_sum  = w_sub ? ({1'b0, w_al_b} - {1'b0, w_al_s})
                   : ({1'b0, w_al_b} + {1'b0, w_al_s});

    w_lead = '0;
    for (int unsigned i = 0; i < AW + 1; i++) begin
      if (w_sum[i]) w_lead = LW'(i);
    end
    w_nsc  = w_big.sc + SCW'(w_lead) - SCW'(AW - 1);
    w_norm = w_sum << (LW'(AW) - w_lead);

    // Regime built by sign-extending a 2-bit seed: "10" grows a run of 1s,
    // "01" a run of 0s; exponent and fraction follow in the same word.
    w_k  = w_nsc >>> es;
    w_sh = (w_k >= 0) ? w_k : (-w_k - SCW'(1));
    w_x  = {(w_k >= 0) ? 2'b10 : 2'b01, w_nsc[es-1:0], w_norm[AW-1:0], {XPAD{1'b0}}};
    w_xs = w_x >>> w_sh;

    w_body = w_xs[XW-1 -: N-1];
    w_rnd  = w_xs[XW-N];
    w_st   = |w_xs[XW-N-1:0];
    w_body = w_body + {{(N-2){1'b0}}, w_rnd & (w_st | w_body[0])};
    if (w_k > KMAX)       w_body = '1;
    else if (w_k < -KMAX) w_body = (N-1)'(1);
    w_mag_out = w_sign ? -{1'b0, w_body} : {1'b0, w_body};

    if ((in1 == NAR) || (in2 == NAR)) w_out = NAR;
    else if (in1 == '0)               w_out = in2;
    else if (in2 == '0)               w_out = in1;
    else if (w_sum == '0)             w_out = '0;
    else                              w_out = w_mag_out;
  end

  // Output registers: capture on start, done pulses for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out  <= '0;
      r_inf  <= 1'b0;
      r_zero <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= start;
      if (start) begin
        r_out  <= w_out;
        r_inf  <= (w_out == NAR);
        r_zero <= (w_out == '0);
      end
    end
  end

  assign out  = r_out;
  assign inf  = r_inf;
  assign zero = r_zero;
  assign done = r_done;

endmodule

// File: tb/tb_posit_add.sv
// tb_posit_add: directed vector table, hand sequences for reset/pipelining,
// and random operands checked against an exact-arithmetic posit model.
module tb_posit_add;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [15:0] in1, in2, out;
  logic        inf, zero, done;

  int n_checks = 0;
  int n_fail   = 0;

  posit_add #(.N(16), .es(2)) dut (
    .clk(clk), .rst_n(rst_n), .in1(in1), .in2(in2), .start(start),
    .out(out), .inf(inf), .zero(zero), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] y;
  } vec_t;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h, required 0x%04h", name, act, req);
    end
  endtask

  // Exact value of a posit in units of 2^-56 (every posit16/es2 is a multiple).
  function automatic logic signed [127:0] posit_value(input logic [15:0] p);
    logic [15:0]  a;
    logic [127:0] mag;
    int pos, m, k, e, nf, scale;
    if (p == 16'h0000) return '0;
    a = p[15] ? -p : p;
    pos = 14; m = 0;
    while (pos >= 0 && a[pos] == a[14]) begin m++; pos--; end
    k = a[14] ? m - 1 : -m;
    pos--;
    e = 0;
    for (int j = 0; j < 2; j++) begin
      e = e * 2 + ((pos >= 0) ? int'(a[pos]) : 0);
      pos--;
    end
    mag = 128'd1; nf = 0;
    for (; pos >= 0; pos--) begin mag = {mag[126:0], a[pos]}; nf++; end
    scale = k * 4 + e;
    mag = (mag << (scale + 56)) >> nf;
    return p[15] ? -$signed(mag) : $signed(mag);
  endfunction

  // Encode an exact value: write the unbounded bit string, then round
  // to nearest-even at bit 15 and clamp to minpos/maxpos.
  function automatic logic [15:0] posit_encode(input logic signed [127:0] v);
    logic [127:0] m;
    logic [14:0]  body;
    bit           q[$];
    bit           rnd, st;
    int p, scale, k, e;
    if (v == 0) return 16'h0000;
    m = (v < 0) ? -v : v;
    p = 0;
    for (int i = 0; i < 128; i++) if (m[i]) p = i;
    scale = p - 56;
    k = (scale >= 0) ? scale / 4 : -((3 - scale) / 4);
    e = scale - 4 * k;
    if (k > 14)       body = 15'h7FFF;
    else if (k < -14) body = 15'h0001;
    else begin
      if (k >= 0) begin repeat (k + 1) q.push_back(1'b1); q.push_back(1'b0); end
      else begin repeat (-k) q.push_back(1'b0); q.push_back(1'b1); end
      q.push_back(bit'(e / 2));
      q.push_back(bit'(e % 2));
      for (int i = p - 1; i >= 0; i--) q.push_back(m[i]);
      while (q.size() < 17) q.push_back(1'b0);
      body = '0;
      for (int i = 0; i < 15; i++) body = {body[13:0], q[i]};
      rnd = q[15];
      st  = 1'b0;
      for (int i = 16; i < q.size(); i++) st |= q[i];
      if (rnd && (st || body[0])) body = body + 15'd1;
    end
    return (v < 0) ? -{1'b0, body} : {1'b0, body};
  endfunction

  function automatic logic [15:0] model_sum(input logic [15:0] a, input logic [15:0] b);
    if (a == 16'h8000 || b == 16'h8000) return 16'h8000;
    return posit_encode(posit_value(a) + posit_value(b));
  endfunction

  function automatic logic [15:0] pick_operand();
    int unsigned r;
    logic [15:0] x;
    r = $urandom_range(0, 99);
    x = 16'($urandom);
    if (r < 8)       x = 16'h0000;
    else if (r < 12) x = 16'h8000;
    else if (r < 22) x = {x[15], (x[14] ? 11'h7FF : 11'h000), x[3:0]};
    return x;
  endfunction

  // Drive one operation (start held high) and check its result after the edge.
  task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] y);
    @(negedge clk);
    in1 = a; in2 = b; start = 1'b1;
    @(posedge clk);
    #1;
    check({name, " out"},  out, y);
    check({name, " inf"},  {15'b0, inf},  {15'b0, (y == 16'h8000)});
    check({name, " zero"}, {15'b0, zero}, {15'b0, (y == 16'h0000)});
    check({name, " done"}, {15'b0, done}, 16'h0001);
  endtask

  vec_t        tbl[$];
  logic [15:0] a, b, last;

  initial begin
    rst_n = 1'b1; start = 1'b0; in1 = '0; in2 = '0;
    #1 rst_n = 1'b0;
    #1;
    check("reset out",  out,  16'h0000);
    check("reset inf",  {15'b0, inf},  16'h0000);
    check("reset zero", {15'b0, zero}, 16'h0000);
    check("reset done", {15'b0, done}, 16'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    tbl.push_back('{16'h0000, 16'h0000, 16'h0000});
    tbl.push_back('{16'h4000, 16'h0000, 16'h4000});
    tbl.push_back('{16'h0000, 16'hC400, 16'hC400});
    tbl.push_back('{16'h4000, 16'h4000, 16'h4800});
    tbl.push_back('{16'h2000, 16'h2000, 16'h2800});
    tbl.push_back('{16'h7000, 16'h7000, 16'h7200});
    tbl.push_back('{16'h4000, 16'h4400, 16'h4A00});
    tbl.push_back('{16'h4000, 16'hC000, 16'h0000});
    tbl.push_back('{16'hC000, 16'hC000, 16'hB800});
    tbl.push_back('{16'hC000, 16'h4800, 16'h4000});
    tbl.push_back('{16'h8000, 16'h4000, 16'h8000});
    tbl.push_back('{16'h0000, 16'h8000, 16'h8000});
    tbl.push_back('{16'h8000, 16'h8000, 16'h8000});
    tbl.push_back('{16'h7FFF, 16'h7FFF, 16'h7FFF});
    tbl.push_back('{16'h8001, 16'h8001, 16'h8001});
    tbl.push_back('{16'h0001, 16'h0001, 16'h0001});
    tbl.push_back('{16'h0001, 16'hFFFF, 16'h0000});
    for (int i = 0; i < tbl.size(); i++)
      run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].y);

    // start low: done drops, results hold
    @(negedge clk) start = 1'b0; in1 = 16'h4000; in2 = 16'h4000;
    @(posedge clk); #1;
    check("idle done", {15'b0, done}, 16'h0000);
    check("idle hold", out, 16'h0000);

    // three back-to-back operations, then idle
    run_op("pipe0", 16'h4000, 16'h4000, 16'h4800);
    run_op("pipe1", 16'h2000, 16'h2000, 16'h2800);
    run_op("pipe2", 16'h7000, 16'h7000, 16'h7200);
    @(negedge clk) start = 1'b0; in1 = 16'h0000; in2 = 16'h0000;
    @(posedge clk); #1;
    check("pipe idle done", {15'b0, done}, 16'h0000);
    check("pipe idle hold", out, 16'h7200);

    // asynchronous reset in the middle of an accepted operation
    run_op("pre-reset", 16'h4000, 16'h4000, 16'h4800);
    @(negedge clk);
    in1 = 16'h7000; in2 = 16'h7000; start = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("async rst out",  out, 16'h0000);
    check("async rst done", {15'b0, done}, 16'h0000);
    check("async rst inf",  {15'b0, inf},  16'h0000);
    @(posedge clk); #1;
    check("in-reset done", {15'b0, done}, 16'h0000);
    @(negedge clk) rst_n = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    check("discarded done", {15'b0, done}, 16'h0000);
    check("discarded out",  out, 16'h0000);
    run_op("first after reset", 16'h2000, 16'h2000, 16'h2800);

    // random back-to-back operands against the exact model
    for (int i = 0; i < 400; i++) begin
      a = pick_operand();
      b = pick_operand();
      run_op($sformatf("rnd%0d %04h+%04h", i, a, b), a, b, model_sum(a, b));
    end
    last = out;
    @(negedge clk) start = 1'b0;
    @(posedge clk); #1;
    check("final hold", out, last);
    check("final done", {15'b0, done}, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/posit_add.md
# posit_add

Single-cycle registered posit adder for standard posits (default N=16, es=2). Used in the FFT datapath wherever two posit operands are summed (butterfly add/subtract with pre-negated operand). Decodes both operands, aligns and adds significands, then normalises, rounds and re-encodes. Flags NaR and zero results.

## Interface
- N, 16, posit word width in bits; verified at 16.
- es, 2, exponent field width; verified at 2.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in1  input  N  first posit operand (two's-complement posit encoding).
- in2  input  N  second posit operand.
- start  input  1  operand-valid; in1/in2 captured on the rising clk edge where start=1.
- out  output  N  posit sum, registered.
- inf  output  1  result is NaR (0x8000 at N=16), registered.
- zero  output  1  result is exactly zero, registered.
- done  output  1  one-cycle pulse: out/inf/zero valid for the operation accepted on the previous edge.

## Operation
- Special cases, checked first:
  - Either operand is NaR (1 followed by N-1 zeros): out=NaR, inf=1, zero=0.
  - Both operands 0: out=0, zero=1, inf=0.
  - Exactly one operand 0: out = the other operand unchanged, zero=0, inf=0.
- Decode: sign = MSB; negative operands are two's-complemented before field extraction.
- Regime: run of identical bits after the sign, length m, terminated by the opposite bit or end of word. k = m-1 for a run of 1s, k = -m for a run of 0s.
- Exponent: next es bits, zero-padded if truncated.
- Fraction: remaining bits with hidden 1.
- Scale = k*2^es + exp. The larger-magnitude operand (larger scale, then larger fraction) is the base.
- The smaller significand is right-shifted by the scale difference. Shifted-out bits are collected into guard, round and sticky bits; shift saturates at significand width and beyond.
- Equal signs: add significands; carry-out increments the scale. Unequal signs: subtract smaller from larger.
- Result sign = base operand sign. Exact cancellation gives out=0, zero=1.
- Normalise with a leading-zero detector; decrement the scale by the shift.
- Encode regime, exponent and fraction, then round to nearest, ties to even, on the bits beyond N-1.
- The result never rounds to 0 or NaR. Clamp magnitude to maxpos (0x7FFF = 2^56) or minpos (0x0001 = 2^-56).
- Negative results are two's-complemented at the end.
- zero=1 iff out==0; inf=1 iff out==NaR. They are never both 1.

## Timing
- Latency 1: operands captured at edge T when start=1; out/inf/zero/done updated at edge T.
- Results are visible after edge T and done=1 for exactly the cycle following T.
- start=0 at an edge: done drops to 0 and out/inf/zero hold their last values.
- Back-to-back start accepted every cycle. done stays high and results update each cycle.
- No backpressure; start is never refused.
- rst_n low, asynchronous: out=0, inf=0, zero=0, done=0 immediately.
- Reset during an operation discards it; no done is produced for it.
- First valid capture is the first edge with rst_n high and start=1.
- Arithmetic is purely combinational between the input and output registers. The full decode/add/encode path must close timing within one clock.

## Test plan
- Reset: assert rst_n=0 mid-stream -> out=0x0000, inf=0, zero=0, done=0 without a clock edge.
- Zeros and identity: 0x0000+0x0000 -> 0x0000, zero=1. 0x4000+0x0000 -> 0x4000, zero=0. One cycle later, done=1 for one cycle.
- Exact sums:
  - 0x4000+0x4000 (1+1) -> 0x4800.
  - 0x2000+0x2000 (1/16+1/16) -> 0x2800.
  - 0x7000+0x7000 (256+256) -> 0x7200.
  - 0x4000+0x4400 (1+1.5) -> 0x4A00.
- Cancellation and signs: 0x4000+0xC000 (1+(-1)) -> 0x0000, zero=1. 0xC000+0xC000 -> 0xB800 (-2).
- NaR and saturation: 0x8000+0x4000 -> 0x8000, inf=1. 0x7FFF+0x7FFF -> 0x7FFF. 0x0001+0x0001 -> nonzero per round-to-nearest-even, never 0x0000.
- Pipelining: start high 3 consecutive cycles with different operands -> done high 3 cycles, each result matching its operands one cycle after capture; start low -> done low, out holds.
